// File: rtl/c2c_pkg.sv
// Shared types for the core-to-cache write buffer: entry layout, word-index width
// and the lane-wise byte merge used when stores coalesce.
package c2c_pkg;

  localparam int C2C_XLEN   = 32;
  localparam int C2C_NB     = C2C_XLEN / 8;
  localparam int C2C_OFFW   = $clog2(C2C_NB);
  localparam int C2C_WIDX_W = C2C_XLEN - C2C_OFFW;

  typedef struct packed {
    logic [C2C_WIDX_W-1:0] widx;
    logic [C2C_NB-1:0]     sel;
    logic [C2C_XLEN-1:0]   data;
  } wb_entry_t;

  // Bytes whose enable is set come from new_d, the rest keep old_d.
  function automatic logic [C2C_XLEN-1:0] byte_merge(input logic [C2C_XLEN-1:0] old_d,
                                                     input logic [C2C_XLEN-1:0] new_d,
                                                     input logic [C2C_NB-1:0]   be);
    logic [C2C_XLEN-1:0] r;
    r = old_d;
    for (int b = 0; b < C2C_NB; b++)
      if (be[b]) r[8*b +: 8] = new_d[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/c2c_write_buffer.sv
// In-order store buffer between the core write channel and the memory write port,
// with a load hazard check. Define C2C_WB_COALESCE_EN to merge same-word stores into the tail.
module c2c_write_buffer
  import c2c_pkg::*;
#(
  parameter int XLEN  = C2C_XLEN,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [XLEN/8-1:0] sel,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   data,
  output logic              ack,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_sel,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_data,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   ld_addr,
  output logic              ld_hit,
  output logic              empty
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);

  wb_entry_t         ent_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              ack_q;

  logic              req, full, merge, alloc, pop;
  logic [XLEN-OFFW-1:0] word, ld_word;
  wb_entry_t         head;

  // Byte offsets never take part in matching or storage.
  logic unused_lowbits;
  assign unused_lowbits = ^{addr[OFFW-1:0], ld_addr[OFFW-1:0]};

  assign word    = addr[XLEN-1:OFFW];
  assign ld_word = ld_addr[XLEN-1:OFFW];
  assign req     = we && !ack_q;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = !empty && mem_ack;

`ifdef C2C_WB_COALESCE_EN
  logic [PW-1:0] tail_ptr;
  assign tail_ptr = wr_ptr_q - PW'(1);
  // count>=2 keeps the head, which may be mid-handshake on the mem port, untouched.
  assign merge = req && (count_q >= CW'(2)) && (ent_q[tail_ptr].widx == word);
`else
  assign merge = 1'b0;
`endif

  assign alloc = req && !merge && !full;

  assign head     = ent_q[rd_ptr_q];
  assign ack      = ack_q;
  assign mem_we   = !empty;
  assign mem_sel  = head.sel;
  assign mem_addr = {head.widx, {OFFW{1'b0}}};
  assign mem_data = head.data;

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && ent_q[i].widx == ld_word) ld_hit = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= alloc || merge;
      if (alloc) begin
        ent_q[wr_ptr_q] <= '{widx: word, sel: sel, data: data};
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
`ifdef C2C_WB_COALESCE_EN
      if (merge) begin
        ent_q[tail_ptr].sel  <= ent_q[tail_ptr].sel | sel;
        ent_q[tail_ptr].data <= byte_merge(ent_q[tail_ptr].data, data, sel);
      end
`endif
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PW'(1);
      end
      case ({alloc, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_c2c_write_buffer.sv
// Directed bench for c2c_write_buffer: drained stores are checked against a scoreboard
// queue by an independent monitor; handshake and hazard outputs are checked inline.
module tb_c2c_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n, we, mem_ack;
  logic [3:0]  sel;
  logic [31:0] addr, data, ld_addr;
  logic        ack, mem_we, ld_hit, empty;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_data;

  typedef struct { logic [31:0] a; logic [3:0] s; logic [31:0] d; } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, n_drained = 0;

  c2c_write_buffer #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .sel(sel), .addr(addr), .data(data), .ack(ack),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ack(mem_ack), .ld_addr(ld_addr), .ld_hit(ld_hit), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted drain must match the oldest expected store.
  always @(negedge clk) begin
    if (rst_n && mem_we === 1'b1 && mem_ack === 1'b1) begin
      n_drained++;
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL drain_unexpected: got addr %h want no drain", mem_addr);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("drain_addr", mem_addr, e.a);
        chk("drain_sel", {28'd0, mem_sel}, {28'd0, e.s});
        chk("drain_data", mem_data, e.d);
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    exp_t e;
    e.a = a; e.s = s; e.d = d;
    q.push_back(e);
  endtask

  // Issue one store and wait for its ack; returns in the ack cycle with we dropped.
  task automatic store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       input bit do_push, input bit rnd);
    bit got;
    got = 1'b0;
    we = 1'b1; addr = a; sel = s; data = d;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) got = 1'b1;
      if (rnd) mem_ack = 1'($urandom_range(0, 1));
    end
    we = 1'b0;
    chk("store_ack", {31'd0, got}, 32'd1);
    if (got && do_push) push(a, s, d);
  endtask

  task automatic drain();
    mem_ack = 1'b1;
    for (int c = 0; c < 60 && empty !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    chk("drain_empty", {31'd0, empty}, 32'd1);
    chk("sb_left", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, j;
    rst_n = 1'b0; we = 1'b0; sel = '0; addr = '0; data = '0; mem_ack = 1'b0; ld_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_ld_hit", {31'd0, ld_hit}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single store, memory always ready
    mem_ack = 1'b1;
    we = 1'b1; addr = 32'h100; sel = 4'hF; data = 32'hDEADBEEF;
    push(32'h100, 4'hF, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("single_ack", {31'd0, ack}, 32'd1);
    chk("single_mem_we", {31'd0, mem_we}, 32'd1);
    chk("single_mem_addr", mem_addr, 32'h100);
    we = 1'b0;
    @(posedge clk); #1;
    chk("single_empty", {31'd0, empty}, 32'd1);
    chk("single_ack_low", {31'd0, ack}, 32'd0);
    mem_ack = 1'b0;

    // Fill to DEPTH, then a fifth store stalls until one entry drains
    for (int i = 0; i < 4; i++) store(32'(4 * i), 4'hF, 32'h1000 + 32'(i), 1'b1, 1'b0);
    we = 1'b1; addr = 32'h10; sel = 4'hC; data = 32'h55AA0000;
    repeat (3) begin
      @(posedge clk); #1;
      chk("full_stall", {31'd0, ack}, 32'd0);
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    chk("full_no_bypass", {31'd0, ack}, 32'd0);
    mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("full_accept", {31'd0, ack}, 32'd1);
    push(32'h10, 4'hC, 32'h55AA0000);
    we = 1'b0;
    drain();

    // Pointer wrap under random backpressure
    base = n_drained;
    for (int i = 0; i < 10; i++)
      store(32'h300 + 32'(4 * i), 4'(i * 3 + 1), 32'hA5000000 | 32'(i * 17), 1'b1, 1'b1);
    drain();
    chk("wrap_count", 32'(n_drained - base), 32'd10);

    // Load hazard check
    store(32'h204, 4'hF, 32'h12345678, 1'b1, 1'b0);
    ld_addr = 32'h206; #1;
    chk("hazard_hit", {31'd0, ld_hit}, 32'd1);
    ld_addr = 32'h208; #1;
    chk("hazard_miss", {31'd0, ld_hit}, 32'd0);
    drain();
    ld_addr = 32'h206; #1;
    chk("hazard_after_drain", {31'd0, ld_hit}, 32'd0);

    // Held request: we stays high through the ack cycle -> single accept
    we = 1'b1; addr = 32'h600; sel = 4'hF; data = 32'h60;
    @(posedge clk); #1;
    chk("held_ack", {31'd0, ack}, 32'd1);
    if (ack === 1'b1) push(32'h600, 4'hF, 32'h60);
    @(posedge clk); #1;
    chk("held_no_dup", {31'd0, ack}, 32'd0);
    we = 1'b0;
    @(posedge clk); #1;
    chk("held_idle", {31'd0, ack}, 32'd0);
    // Continuous we: one accept every second cycle
    j = 0;
    we = 1'b1; addr = 32'h700; data = 32'h700;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("cont_ack", {31'd0, ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (ack === 1'b1) begin
        push(addr, sel, data);
        j++;
        addr = 32'h700 + 32'(4 * j); data = 32'h700 + 32'(j);
      end
    end
    we = 1'b0;
    drain();

    // Same-word stores: merged with coalescing, separate entries otherwise
    base = n_drained;
    store(32'h40, 4'h3, 32'h0000AAAA, 1'b1, 1'b0);
    store(32'h80, 4'h1, 32'h000000CC, 1'b0, 1'b0);
    store(32'h80, 4'h2, 32'h0000BB00, 1'b0, 1'b0);
    ld_addr = 32'h82; #1;
    chk("coal_ld_hit", {31'd0, ld_hit}, 32'd1);
`ifdef C2C_WB_COALESCE_EN
    push(32'h80, 4'h3, 32'h0000BBCC);
    drain();
    chk("coal_entries", 32'(n_drained - base), 32'd2);
`else
    push(32'h80, 4'h1, 32'h000000CC);
    push(32'h80, 4'h2, 32'h0000BB00);
    drain();
    chk("coal_entries", 32'(n_drained - base), 32'd3);
`endif

    // Asynchronous reset while an ack is showing and a store is queued
    store(32'h900, 4'hF, 32'h9, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ack", {31'd0, ack}, 32'd0);
    chk("arst_empty", {31'd0, empty}, 32'd1);
    chk("arst_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    store(32'hA00, 4'h5, 32'hCAFEF00D, 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/c2c_write_buffer.md
# c2c_write_buffer

Cache-side responder for the core-to-cache write channel: accepts core stores (we/sel/addr/data, answered with ack), queues them in a small FIFO, and drains them in order to the memory/cache write port. It sits between the core's store path and the data-cache array or bus bridge. It decouples store retirement from memory latency and gives the load path a hazard check against pending stores.

## Interface
- XLEN, 32, data/address width; byte lanes NB = XLEN/8
- DEPTH, 4, buffer entries; power of two, ≥2
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- we  in  1  core write request (c2c_w slave side)
- sel  in  NB  byte enables
- addr  in  XLEN  byte address
- data  in  XLEN  write data, lane-aligned
- ack  out  1  one-cycle accept pulse to core
- mem_we  out  1  drain request to memory
- mem_sel  out  NB  head entry byte enables
- mem_addr  out  XLEN  head entry address, low log2(NB) bits zero
- mem_data  out  XLEN  head entry data
- mem_ack  in  1  memory accepted the drain request
- ld_addr  in  XLEN  load address to check
- ld_hit  out  1  some valid entry matches ld_addr's word
- empty  out  1  no valid entries

## Operation
- Word match: compare addr[XLEN-1:log2(NB)]; low bits ignored everywhere.
- Accept: cycle N with we=1, ack=0, count<DEPTH → entry written at tail, count+1, ack=1 in N+1.
- While ack=1, we is ignored. This lets the master still hold the just-accepted request without a double accept.
- Full (count==DEPTH at start of cycle): request stalls, no ack, request held by master. No same-cycle bypass of a pop.
- Drain: mem_we = !empty; mem_sel/addr/data driven from head entry registers. Head is held stable until mem_ack=1. The pop happens on that edge, and the next head is presented the following cycle. mem_ack with mem_we=0 is ignored.
- Simultaneous accept and pop: both take effect, count unchanged.
- Pointers: log2(DEPTH) bits, natural wrap. Count: log2(DEPTH+1) bits.
- ld_hit: combinational OR over valid entries of word match with ld_addr; 0 when empty.
- Stores with sel=0 are accepted and queued like any other.

## Timing
- Reset values: ack=0, mem_we=0, mem_sel=0, mem_addr=0, mem_data=0, empty=1, ld_hit=0, all entries invalid, pointers/count 0.
- Accept latency: ack one cycle after the request is sampled. Maximum core throughput is one store per 2 cycles.
- Entry visible on mem_* the cycle after acceptance if the buffer was empty (store→mem_we latency 1).
- ld_hit reflects entries accepted up to the previous edge. An in-flight request in the current cycle is not included.
- Reset mid-operation: all queued stores are discarded and ack drops immediately, asynchronously.

## Configuration
- C2C_WB_COALESCE_EN defined: an accepted request whose word matches the tail entry merges into it, provided count≥2 (the tail is not the head on the mem port). Merge rule: data bytes with sel=1 overwrite, tail sel |= sel, count unchanged, ack timing identical. Merge is permitted even when the buffer is full.
- Undefined: every accepted request allocates a new entry. Full always stalls.

## Structure
- Shared package c2c_pkg holds:
  - wb_entry_t: word address, sel, data
  - the byte-merge function (lane-wise select on sel)
  - the word-index width constant derived from XLEN
- No sub-module. Storage, pointers, and match logic stay in one module, since the FIFO is too entangled with coalescing and the hazard check to split out.

## Test plan
- Reset, then a single store: addr=0x100, sel=0xF, data=0xDEADBEEF, mem_ack tied 1. Required: ack one cycle later, mem_we=1 with the same values the next cycle, empty=1 after the pop.
- Fill: 4 stores to 0x0,0x4,0x8,0xC with mem_ack=0. Required: 4 acks; a 5th store (0x10) gets no ack until mem_ack=1 for 1 cycle, then is acked; drain order is 0x0,0x4,0x8,0xC,0x10.
- Pointer wrap: 10 stores with random mem_ack backpressure. Required: memory sees all 10 in order with exact sel/data; no loss or duplication.
- Hazard: pending store to 0x204 with mem_ack=0. Required: ld_addr=0x206 → ld_hit=1; ld_addr=0x208 → ld_hit=0; after the drain completes, ld_hit=0.
- Held request: we held high 3 cycles for one store. Required: exactly one ack and one entry per acceptance window; continuous we produces accepts every 2 cycles.
- With C2C_WB_COALESCE_EN, mem_ack=0: stores 0x40 (sel=0x3, data=0x0000AAAA), then 0x80 (sel=0x1), then 0x80 (sel=0x2, data=0x0000BB00). Required: count=2, the 0x80 entry has sel=0x3 with bytes merged. Without the macro: count=3.
